i2c_cfg_sequencer: RTL
======================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Upstream feeder for the I2C write controller: walks a fixed table of codec register writes (WM8731-style 7b reg + 9b data).
//  Issues each as one 3-byte transaction (dev addr+W, data1, data2) and waits for completion or NACK.
//  Retries NACKed writes, spaces writes by a gap, and reports overall done/error to the system.
// PARAMETERS
//  NUM_REGS    10      entries in config table (1..16)
//  DEV_ADDR    7'h1A   7-bit I2C device address; addr byte = {DEV_ADDR,1'b0}
//  MAX_RETRY   3       attempts per entry before ERROR (1..7)
//  GAP_CYCLES  1000    clk cycles idle between transactions (>=1, 16-bit counter)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  start_cfg    in   1   pulse: begin sequence (honoured in IDLE/DONE/ERROR only)
//  txn_done     in   1   pulse from controller: transaction completed, all ACKs good
//  txn_nack     in   1   pulse from controller: transaction aborted on NACK
//  txn_req      out  1   level: request transaction; held until txn_done/txn_nack
//  txn_addr     out  8   address byte, constant {DEV_ADDR,0}
//  txn_data1    out  8   {reg[6:0], data[8]}
//  txn_data2    out  8   data[7:0]
//  reg_index    out  4   table entry in progress
//  cfg_busy     out  1   high outside IDLE/DONE/ERROR
//  cfg_done     out  1   level: all entries written, cleared by start_cfg
//  cfg_error    out  1   level: retries exhausted, cleared by start_cfg
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx=0, retry=0, gap counter=0. Reset mid-transaction drops txn_req same edge.
//  States: IDLE, LOAD, REQ, WAIT, GAP, DONE, ERROR (4-bit encoding).
//  IDLE/DONE/ERROR --start_cfg--> LOAD; idx=0, retry=0, cfg_done=cfg_error=0.
//  LOAD: registered ROM read of entry idx (1 cycle); data1/data2 latched -> REQ.
//  REQ: txn_req=1 next cycle; txn_addr/data1/data2 stable while txn_req=1 -> WAIT.
//  WAIT: txn_req held 1. txn_done: txn_req=0, retry=0; if idx==NUM_REGS-1 -> DONE else GAP (advance=1).
//   txn_nack: txn_req=0, retry++; if retry+1==MAX_RETRY -> ERROR else GAP (advance=0).
//   txn_done and txn_nack same cycle: NACK wins.
//  GAP: count GAP_CYCLES cycles; then idx+=advance -> LOAD.
//  DONE: cfg_done=1. ERROR: cfg_error=1, reg_index frozen at failing entry.
//  start_cfg while cfg_busy: ignored. txn_done/txn_nack outside WAIT: ignored.
//  Latency start_cfg -> txn_req rising: 2 cycles (LOAD, REQ).
//  reg_index = idx (4b), no wrap: idx never exceeds NUM_REGS-1.
// CONFIGURATION
//  I2C_CFG_AUTOSTART_EN defined: first cycle after reset deassertion acts as start_cfg (one-shot, reset re-arms).
//  Not defined: sequence starts only on start_cfg; block idles in IDLE after reset.
// STRUCTURE
//  Shared header i2c_cfg_states.vh: state localparams, STATE_W=4, IDX_W=4, GAP_W=16.
//  Sub-module i2c_cfg_rom: idx[3:0] -> {reg[6:0],data[8:0]} case table; default entry 16'h0000.
//  Top: FSM, idx/retry/gap counters, output registers.
// TESTING
//  Reset then start_cfg, controller acks every req with txn_done 5 cycles later -> 10 txns, entry0 data1/data2 match ROM, cfg_done=1, gap=1000 cycles.
//  NACK entry 3 once, then done -> entry 3 reissued after gap, same data bytes; sequence completes, cfg_error=0.
//  NACK entry 3 on all 3 attempts -> cfg_error=1, reg_index=3, txn_req=0, no further reqs.
//  txn_done and txn_nack same cycle on entry 0 -> treated as NACK (retry, entry 0 repeated).
//  start_cfg pulsed during WAIT of entry 2 -> ignored; reset asserted in WAIT -> txn_req=0 next edge, all outputs 0.
//  With I2C_CFG_AUTOSTART_EN: no start_cfg, txn_req rises 3 cycles after reset falls; without it stays 0 for 5000 cycles.

Source files
------------

// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared types and widths for the codec configuration sequencer.
// Replaces the old i2c_cfg_states.vh header (state encodings, STATE_W/IDX_W/GAP_W).
package i2c_cfg_sequencer_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned GAP_W   = 16;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_REQ   = 4'd2,
    ST_WAIT  = 4'd3,
    ST_GAP   = 4'd4,
    ST_DONE  = 4'd5,
    ST_ERROR = 4'd6
  } state_e;

  // WM8731-style register write: 7-bit register address, 9-bit value
  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } cfg_entry_t;

  function automatic logic [7:0] data1_byte(input cfg_entry_t e);
    return {e.reg_addr, e.data[8]};
  endfunction

  function automatic logic [7:0] data2_byte(input cfg_entry_t e);
    return e.data[7:0];
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Transaction handshake between the config sequencer (master) and the I2C write controller (slave).
interface i2c_cfg_sequencer_if;

  logic       txn_req;
  logic [7:0] txn_addr;
  logic [7:0] txn_data1;
  logic [7:0] txn_data2;
  logic       txn_done;
  logic       txn_nack;

  modport master (
    output txn_req, txn_addr, txn_data1, txn_data2,
    input  txn_done, txn_nack
  );

  modport slave (
    input  txn_req, txn_addr, txn_data1, txn_data2,
    output txn_done, txn_nack
  );

endinterface

// File: rtl/i2c_cfg_sequencer_rom.sv
// Fixed codec init table: idx -> {reg[6:0], data[8:0]}; unused entries read as zero.
module i2c_cfg_rom
  import i2c_cfg_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = '0;
    case (idx)
      4'd0:    entry = '{reg_addr: 7'h0F, data: 9'h000};  // reset
      4'd1:    entry = '{reg_addr: 7'h06, data: 9'h000};  // power down control
      4'd2:    entry = '{reg_addr: 7'h00, data: 9'h017};  // left line in
      4'd3:    entry = '{reg_addr: 7'h01, data: 9'h017};  // right line in
      4'd4:    entry = '{reg_addr: 7'h02, data: 9'h079};  // left headphone
      4'd5:    entry = '{reg_addr: 7'h03, data: 9'h079};  // right headphone
      4'd6:    entry = '{reg_addr: 7'h04, data: 9'h012};  // analog path
      4'd7:    entry = '{reg_addr: 7'h05, data: 9'h000};  // digital path
      4'd8:    entry = '{reg_addr: 7'h07, data: 9'h042};  // digital interface
      4'd9:    entry = '{reg_addr: 7'h09, data: 9'h001};  // activate
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the codec init table, issuing one 3-byte I2C write per entry with retry and inter-write gap.
// Optional: define I2C_CFG_AUTOSTART_EN to start the sequence automatically after reset.
module i2c_cfg_sequencer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 10,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_cfg,
  i2c_cfg_sequencer_if.master  txn,
  output logic [IDX_W-1:0]     reg_index,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_error
);

  localparam logic [7:0]         ADDR_BYTE  = {DEV_ADDR, 1'b0};
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               advance_q, advance_d;
  logic               txn_req_q, txn_req_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data1_q, data1_d;
  logic [7:0]         data2_q, data2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               start_go;
  cfg_entry_t         rom_entry;

`ifdef I2C_CFG_AUTOSTART_EN
  logic autostart_q;

  // Armed by reset, consumed on the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) autostart_q <= 1'b1;
    else       autostart_q <= 1'b0;
  end

  assign start_go = start_cfg | autostart_q;
`else
  assign start_go = start_cfg;
`endif

  i2c_cfg_rom u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    advance_d = advance_q;
    txn_req_d = txn_req_q;
    addr_d    = addr_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_go) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          retry_d = '0;
          gap_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        addr_d  = ADDR_BYTE;
        data1_d = data1_byte(rom_entry);
        data2_d = data2_byte(rom_entry);
        state_d = ST_REQ;
      end
      ST_REQ: begin
        txn_req_d = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // NACK is tested first so a simultaneous done/nack counts as a failure
        if (txn.txn_nack) begin
          txn_req_d = 1'b0;
          gap_d     = '0;
          if (retry_q == RETRY_LAST) begin
            state_d = ST_ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            retry_d   = retry_q + 1'b1;
            advance_d = 1'b0;
            state_d   = ST_GAP;
          end
        end else if (txn.txn_done) begin
          txn_req_d = 1'b0;
          retry_d   = '0;
          gap_d     = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            advance_d = 1'b1;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_LOAD;
          if (advance_q) idx_d = idx_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      advance_q <= 1'b0;
      txn_req_q <= 1'b0;
      addr_q    <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      advance_q <= advance_d;
      txn_req_q <= txn_req_d;
      addr_q    <= addr_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign txn.txn_req   = txn_req_q;
  assign txn.txn_addr  = addr_q;
  assign txn.txn_data1 = data1_q;
  assign txn.txn_data2 = data2_q;
  assign reg_index     = idx_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_error     = error_q;

endmodule
